// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-stage access path: widths, FSM encoding,
// default timeout and a word-address helper.
package pipe_pkg;
  localparam int XLEN            = 32;
  localparam int REG_W           = 5;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request/response handshake FSM with an access timeout counter.
// Produces request valid plus complete/stall/err qualifiers for the W register.
module dmem_handshake
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic misaligned,
  input  logic is_load,
  input  logic dmem_ready,
  input  logic dmem_rvalid,
  output logic dmem_req,
  output logic complete,
  output logic stall,
  output logic err
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             req_s;
  logic             stall_raw_s;
  logic             complete_s;
  logic             misal_err_s;
  logic             abort_s;

  // Next-state and handshake qualifiers; rvalid only matters in RESP.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    stall_raw_s = 1'b0;
    complete_s  = 1'b0;
    misal_err_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_REQ: begin
        if (state_r == ST_IDLE && !access) begin
          state_nxt_s = ST_IDLE;
        end else if (state_r == ST_IDLE && misaligned) begin
          misal_err_s = 1'b1;
        end else begin
          req_s = 1'b1;
          if (dmem_ready && !is_load) begin
            complete_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (dmem_ready) begin
            stall_raw_s = 1'b1;
            state_nxt_s = ST_RESP;
          end else begin
            stall_raw_s = 1'b1;
            state_nxt_s = ST_REQ;
          end
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          stall_raw_s = 1'b1;
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A stalled cycle at the limit aborts; a completing cycle never stalls, so completion wins.
  assign abort_s  = stall_raw_s & (count_r == LIMIT);
  assign dmem_req = rst & req_s;
  assign complete = rst & complete_s;
  assign stall    = rst & stall_raw_s & ~abort_s;
  assign err      = rst & (misal_err_s | abort_s);

  // State register and cycle counter; the counter restarts whenever the FSM returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      count_r <= '0;
    end else if (abort_s || state_nxt_s == ST_IDLE) begin
      state_r <= ST_IDLE;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_r + CNT_W'(1);
    end
  end
endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: drives the data-memory port for loads/stores and
// holds the M-to-W pipeline register, inserting bubbles while stalled.
module memory_cycle
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic             ResultSrcM,
  input  logic [REG_W-1:0] RD_M,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [XLEN-1:0]  ALU_ResultM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ready,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             StallM,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic [REG_W-1:0] RD_W,
  output logic [XLEN-1:0]  PCPlus4W,
  output logic [XLEN-1:0]  ALU_ResultW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic             ErrW
);
  logic access_s;
  logic misaligned_s;
  logic is_load_s;
  logic complete_s;
  logic stall_s;
  logic err_s;

  assign access_s     = MemWriteM | ResultSrcM;
  assign misaligned_s = access_s & (ALU_ResultM[1:0] != 2'b00);
  // A store with ResultSrcM also set is still treated as a store.
  assign is_load_s    = ResultSrcM & ~MemWriteM;
  assign dmem_addr    = word_addr(ALU_ResultM);
  assign dmem_wdata   = WriteDataM;
  assign dmem_we      = MemWriteM;
  assign StallM       = stall_s;

  dmem_handshake #(.TIMEOUT(TIMEOUT)) u_handshake (
    .clk         (clk),
    .rst         (rst),
    .access      (access_s),
    .misaligned  (misaligned_s),
    .is_load     (is_load_s),
    .dmem_ready  (dmem_ready),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .complete    (complete_s),
    .stall       (stall_s),
    .err         (err_s)
  );

  // M-to-W register: bubble while stalled, error load on misalign/abort, normal load otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      ErrW        <= 1'b0;
    end else if (stall_s) begin
      RegWriteW <= 1'b0;
      ErrW      <= 1'b0;
    end else begin
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      if (err_s) begin
        RegWriteW <= 1'b0;
        ReadDataW <= '0;
        ErrW      <= 1'b1;
      end else begin
        RegWriteW <= RegWriteM;
        ReadDataW <= (complete_s && is_load_s) ? dmem_rdata : 32'h0000_0000;
        ErrW      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle: default instance for the
// functional cases plus a TIMEOUT=4 instance for the abort case.
module tb_memory_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        dmem_req, dmem_we, StallM, RegWriteW, ResultSrcW, ErrW;
  logic [31:0] dmem_addr, dmem_wdata, PCPlus4W, ALU_ResultW, ReadDataW;
  logic [4:0]  RD_W;

  logic        t_req, t_we, t_stall, t_regwrite, t_resultsrc, t_err;
  logic [31:0] t_addr, t_wdata, t_pc, t_alu, t_rdata;
  logic [4:0]  t_rd;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls;

  always #5 clk = ~clk;

  memory_cycle dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .ErrW(ErrW)
  );

  memory_cycle #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(t_req), .dmem_we(t_we), .dmem_addr(t_addr), .dmem_wdata(t_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(t_stall), .RegWriteW(t_regwrite), .ResultSrcW(t_resultsrc), .RD_W(t_rd),
    .PCPlus4W(t_pc), .ALU_ResultW(t_alu), .ReadDataW(t_rdata), .ErrW(t_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic drive_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    drive_m(1'b1, 1'b0, 1'b1, 5'd3, 32'h4, 32'h0, 32'h40);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",      32'(dmem_req),   32'd0);
    check("rst_stall",    32'(StallM),     32'd0);
    check("rst_regwrite", 32'(RegWriteW),  32'd0);
    check("rst_rd",       32'(RD_W),       32'd0);
    check("rst_alu",      ALU_ResultW,     32'h0);
    check("rst_err",      32'(ErrW),       32'd0);
    rst = 1'b1;

    // Timeout: TIMEOUT=4 instance, load with ready stuck low.
    drive_m(1'b1, 1'b0, 1'b1, 5'd3, 32'h80, 32'h0, 32'h40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_stall", 32'(t_stall), 32'(i < 3));
      check("to_req",   32'(t_req),   32'd1);
      tick();
      check("to_err",      32'(t_err),      32'(i == 3));
      check("to_regwrite", 32'(t_regwrite), 32'd0);
    end
    check("to_alu",   t_alu,   32'h40);
    check("to_rdata", t_rdata, 32'h0);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("to_req_off", 32'(t_req), 32'd0);
    tick();
    check("to_err_pulse", 32'(t_err), 32'd0);

    rst = 1'b0;
    tick();
    rst = 1'b1;

    // ALU op passes straight through.
    drive_m(1'b1, 1'b0, 1'b0, 5'd5, 32'h44, 32'h0, 32'h10);
    @(negedge clk);
    check("alu_stall", 32'(StallM),   32'd0);
    check("alu_req",   32'(dmem_req), 32'd0);
    tick();
    check("alu_regwrite", 32'(RegWriteW), 32'd1);
    check("alu_rd",       32'(RD_W),      32'd5);
    check("alu_result",   ALU_ResultW,    32'h10);
    check("alu_pc",       PCPlus4W,       32'h44);
    check("alu_err",      32'(ErrW),      32'd0);

    // Store accepted immediately.
    drive_m(1'b0, 1'b1, 1'b0, 5'd0, 32'h48, 32'hDEADBEEF, 32'h100);
    dmem_ready = 1'b1;
    @(negedge clk);
    check("st_req",   32'(dmem_req), 32'd1);
    check("st_we",    32'(dmem_we),  32'd1);
    check("st_addr",  dmem_addr,     32'h100);
    check("st_wdata", dmem_wdata,    32'hDEADBEEF);
    check("st_stall", 32'(StallM),   32'd0);
    tick();
    check("st_regwrite", 32'(RegWriteW), 32'd0);
    check("st_alu",      ALU_ResultW,    32'h100);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_ready = 1'b0;
    @(negedge clk);
    check("st_req_off", 32'(dmem_req), 32'd0);
    tick();

    // Load: ready on cycle 2, stray rvalid in REQ on cycle 1, data on cycle 5.
    drive_m(1'b1, 1'b0, 1'b1, 5'd7, 32'h4C, 32'h0, 32'h200);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      dmem_ready  = (i == 2);
      dmem_rvalid = (i == 1) || (i == 5);
      dmem_rdata  = (i == 5) ? 32'h12345678 : 32'hBADBAD00;
      @(negedge clk);
      if (StallM) stalls++;
      check("ld_req", 32'(dmem_req), 32'(i <= 2));
      tick();
      if (i < 5) begin
        check("ld_bubble", 32'(RegWriteW), 32'd0);
        check("ld_hold",   ALU_ResultW,    32'h0);
      end else begin
        check("ld_regwrite", 32'(RegWriteW), 32'd1);
        check("ld_rd",       32'(RD_W),      32'd7);
        check("ld_data",     ReadDataW,      32'h12345678);
        check("ld_alu",      ALU_ResultW,    32'h200);
      end
    end
    check("ld_stalls", 32'(stalls), 32'd5);
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;

    // Misaligned load: no request, one-cycle error.
    drive_m(1'b1, 1'b0, 1'b1, 5'd9, 32'h50, 32'h0, 32'h203);
    @(negedge clk);
    check("mis_req",   32'(dmem_req), 32'd0);
    check("mis_stall", 32'(StallM),   32'd0);
    check("mis_addr",  dmem_addr,     32'h200);
    tick();
    check("mis_err",      32'(ErrW),      32'd1);
    check("mis_regwrite", 32'(RegWriteW), 32'd0);
    check("mis_rdata",    ReadDataW,      32'h0);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("mis_err_pulse", 32'(ErrW), 32'd0);

    // Reset while waiting in RESP, then a late rvalid.
    drive_m(1'b1, 1'b0, 1'b1, 5'd4, 32'h54, 32'h0, 32'h300);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rr_req",       32'(dmem_req),   32'd0);
    check("rr_stall",     32'(StallM),     32'd0);
    check("rr_regwrite",  32'(RegWriteW),  32'd0);
    check("rr_resultsrc", 32'(ResultSrcW), 32'd0);
    check("rr_rd",        32'(RD_W),       32'd0);
    check("rr_pc",        PCPlus4W,        32'h0);
    check("rr_alu",       ALU_ResultW,     32'h0);
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rr_stall_after", 32'(StallM), 32'd0);
    tick();
    check("rr_rdata",  ReadDataW,      32'h0);
    check("rr_regw_w", 32'(RegWriteW), 32'd0);
    dmem_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
